// File: rtl/card_dealer_if.sv
// Draw-request and card-result signals shared between the dealer and its client.
interface card_dealer_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] i_Seed;
  logic             i_Request;
  logic             i_Shuffle;
  logic [3:0]       o_Card;
  logic [3:0]       o_Points;
  logic             o_Valid;
  logic             o_Busy;
  logic             o_Empty;
  logic [5:0]       o_Remaining;

  modport master (
    output i_Seed, i_Request, i_Shuffle,
    input  o_Card, o_Points, o_Valid, o_Busy, o_Empty, o_Remaining
  );

  modport slave (
    input  i_Seed, i_Request, i_Shuffle,
    output o_Card, o_Points, o_Valid, o_Busy, o_Empty, o_Remaining
  );
endinterface

// File: rtl/card_dealer.sv
// Single-deck card dealer: picks a rank from a sampled seed and probes forward
// through the 13 per-rank counters until it finds a rank with cards left.
module card_dealer #(
  parameter int WIDTH = 12
) (
  input logic          clk_50M,
  input logic          i_Reset,
  card_dealer_if.slave bus
);

  typedef enum logic {IDLE, CHECK} state_t;

  state_t           state;
  logic [2:0]       count [13];
  logic [3:0]       idx;
  logic [5:0]       remaining;
  logic [3:0]       card;
  logic [3:0]       points;
  logic             valid;
  logic [WIDTH-1:0] seed;

  function automatic logic [3:0] rank_points(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

  function automatic logic [3:0] next_idx(input logic [3:0] cur);
    return (cur == 4'd12) ? 4'd0 : cur + 4'd1;
  endfunction

  assign seed = bus.i_Seed;

  always_ff @(posedge clk_50M) begin
    valid <= 1'b0;
    if (i_Reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      remaining <= 6'd52;
      card      <= 4'd0;
      points    <= 4'd0;
      for (int r = 0; r < 13; r++) count[r] <= 3'd4;
    end else if (bus.i_Shuffle) begin
      // Card/points are deliberately kept: a shuffle only refills the deck.
      state     <= IDLE;
      remaining <= 6'd52;
      for (int r = 0; r < 13; r++) count[r] <= 3'd4;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_Request && remaining != 6'd0) begin
            idx   <= 4'(seed % WIDTH'(13));
            state <= CHECK;
          end
        end
        CHECK: begin
          // A non-empty deck guarantees some rank is found within 13 probes.
          if (count[idx] != 3'd0) begin
            count[idx] <= count[idx] - 3'd1;
            remaining  <= remaining - 6'd1;
            card       <= idx + 4'd1;
            points     <= rank_points(idx + 4'd1);
            valid      <= 1'b1;
            state      <= IDLE;
          end else begin
            idx <= next_idx(idx);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Card      = card;
  assign bus.o_Points    = points;
  assign bus.o_Valid     = valid;
  assign bus.o_Busy      = (state == CHECK);
  assign bus.o_Remaining = remaining;
  assign bus.o_Empty     = (remaining == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: fixed draw vectors, hand-built probe/abort sequences,
// and a full random 52-card deal checked against a deck model.
module tb_card_dealer;
  logic clk_50M = 1'b0;
  logic i_Reset;
  int   checks = 0;
  int   failures = 0;
  int   deck [13];

  always #10 clk_50M = ~clk_50M;

  card_dealer_if #(.WIDTH(12)) bus ();
  card_dealer #(.WIDTH(12)) dut (.clk_50M(clk_50M), .i_Reset(i_Reset), .bus(bus));

  typedef struct {
    int seed;
    int card;
    int points;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void model_refill();
    for (int r = 0; r < 13; r++) deck[r] = 4;
  endfunction

  function automatic int model_remaining();
    int s = 0;
    for (int r = 0; r < 13; r++) s += deck[r];
    return s;
  endfunction

  // Returns rank 1..13 drawn for this seed and how many empty ranks were skipped.
  function automatic int model_pick(input int seed, output int skips);
    int i = seed % 13;
    skips = 0;
    while (deck[i] == 0) begin
      i = (i + 1) % 13;
      skips++;
    end
    deck[i]--;
    return i + 1;
  endfunction

  task automatic do_shuffle();
    @(negedge clk_50M);
    bus.i_Shuffle = 1'b1;
    @(posedge clk_50M);
    #1;
    bus.i_Shuffle = 1'b0;
    model_refill();
  endtask

  // lat counts edges from the sampling edge (1) to the edge that shows o_Valid.
  task automatic do_draw(input int seed, output int card, output int pts,
                         output int lat, output bit ok, output bit busy0);
    @(negedge clk_50M);
    bus.i_Seed    = 12'(seed);
    bus.i_Request = 1'b1;
    @(posedge clk_50M);
    #1;
    bus.i_Request = 1'b0;
    busy0 = bus.o_Busy;
    lat = 1;
    ok = bus.o_Valid;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk_50M);
      #1;
      lat++;
      if (bus.o_Valid) ok = 1'b1;
    end
    card = bus.o_Card;
    pts  = bus.o_Points;
    if (ok) begin
      @(posedge clk_50M);
      #1;
      check("valid_one_cycle", bus.o_Valid, 0);
    end
  endtask

  task automatic expect_draw(input string name, input int seed, input int ecard,
                             input int epts, input int elat);
    int card, pts, lat;
    bit ok, busy0;
    do_draw(seed, card, pts, lat, ok, busy0);
    check({name, "_valid"}, ok, 1);
    check({name, "_busy"}, busy0, 1);
    check({name, "_card"}, card, ecard);
    check({name, "_points"}, pts, epts);
    check({name, "_latency"}, lat, elat);
  endtask

  initial begin
    int card, pts, lat, skips, exp_card;
    bit ok, busy0;
    int tally [13];

    vecs[0] = '{0, 1, 1};
    vecs[1] = '{12, 13, 10};
    vecs[2] = '{13, 1, 1};
    vecs[3] = '{4095, 1, 1};
    vecs[4] = '{9, 10, 10};
    vecs[5] = '{10, 11, 10};
    vecs[6] = '{11, 12, 10};
    vecs[7] = '{100, 10, 10};

    i_Reset = 1'b1;
    bus.i_Seed = '0;
    bus.i_Request = 1'b0;
    bus.i_Shuffle = 1'b0;
    repeat (2) @(posedge clk_50M);
    #1;
    check("rst_card", bus.o_Card, 0);
    check("rst_points", bus.o_Points, 0);
    check("rst_valid", bus.o_Valid, 0);
    check("rst_busy", bus.o_Busy, 0);
    check("rst_empty", bus.o_Empty, 0);
    check("rst_remaining", bus.o_Remaining, 52);
    @(negedge clk_50M);
    i_Reset = 1'b0;

    // Single draws from a full deck.
    for (int v = 0; v < 8; v++) begin
      do_shuffle();
      expect_draw($sformatf("vec%0d", v), vecs[v].seed, vecs[v].card, vecs[v].points, 2);
      check($sformatf("vec%0d_remaining", v), bus.o_Remaining, 51);
    end

    // Exhaust aces, then one probe; exhaust kings, then wrap 13 -> 1 -> 2.
    do_shuffle();
    for (int n = 0; n < 4; n++) expect_draw("ace", 0, 1, 1, 2);
    expect_draw("probe1", 0, 2, 2, 3);
    for (int n = 0; n < 4; n++) expect_draw("king", 12, 13, 10, 2);
    expect_draw("wrap", 12, 2, 2, 4);
    check("wrap_remaining", bus.o_Remaining, 42);

    // Shuffle during a probing draw aborts it and keeps the last card.
    @(negedge clk_50M);
    bus.i_Seed = 12'd0;
    bus.i_Request = 1'b1;
    @(posedge clk_50M);
    #1;
    bus.i_Request = 1'b0;
    check("abort_sh_busy", bus.o_Busy, 1);
    bus.i_Shuffle = 1'b1;
    @(posedge clk_50M);
    #1;
    bus.i_Shuffle = 1'b0;
    check("abort_sh_valid", bus.o_Valid, 0);
    check("abort_sh_busy_after", bus.o_Busy, 0);
    check("abort_sh_remaining", bus.o_Remaining, 52);
    check("abort_sh_card_held", bus.o_Card, 2);
    check("abort_sh_points_held", bus.o_Points, 2);
    repeat (3) @(posedge clk_50M);
    #1;
    check("abort_sh_no_late_valid", bus.o_Valid, 0);

    // Reset together with shuffle during a probing draw.
    model_refill();
    for (int n = 0; n < 4; n++) expect_draw("ace2", 13, 1, 1, 2);
    @(negedge clk_50M);
    bus.i_Seed = 12'd0;
    bus.i_Request = 1'b1;
    @(posedge clk_50M);
    #1;
    bus.i_Request = 1'b0;
    i_Reset = 1'b1;
    bus.i_Shuffle = 1'b1;
    @(posedge clk_50M);
    #1;
    i_Reset = 1'b0;
    bus.i_Shuffle = 1'b0;
    check("abort_rst_card", bus.o_Card, 0);
    check("abort_rst_points", bus.o_Points, 0);
    check("abort_rst_valid", bus.o_Valid, 0);
    check("abort_rst_busy", bus.o_Busy, 0);
    check("abort_rst_empty", bus.o_Empty, 0);
    check("abort_rst_remaining", bus.o_Remaining, 52);
    repeat (3) @(posedge clk_50M);
    #1;
    check("abort_rst_no_late_valid", bus.o_Valid, 0);

    // Full random deal against the deck model.
    do_shuffle();
    for (int r = 0; r < 13; r++) tally[r] = 0;
    for (int n = 0; n < 52; n++) begin
      int seed = int'($urandom_range(0, 4095));
      exp_card = model_pick(seed, skips);
      do_draw(seed, card, pts, lat, ok, busy0);
      check($sformatf("rnd%0d_valid", n), ok, 1);
      check($sformatf("rnd%0d_card", n), card, exp_card);
      check($sformatf("rnd%0d_points", n), pts, (exp_card > 10) ? 10 : exp_card);
      check($sformatf("rnd%0d_latency", n), lat, 2 + skips);
      check($sformatf("rnd%0d_remaining", n), bus.o_Remaining, model_remaining());
      if (card >= 1 && card <= 13) tally[card - 1]++;
    end
    for (int r = 0; r < 13; r++) check($sformatf("rank%0d_count", r + 1), tally[r], 4);
    check("deal_remaining", bus.o_Remaining, 0);
    check("deal_empty", bus.o_Empty, 1);

    do_draw(5, card, pts, lat, ok, busy0);
    check("empty_req_valid", ok, 0);
    check("empty_req_busy", busy0, 0);

    do_shuffle();
    check("reshuffle_remaining", bus.o_Remaining, 52);
    check("reshuffle_empty", bus.o_Empty, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
